// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers with level, edge, long-press and autorepeat outputs.
// Define DEBOUNCE_BANK_AUTOREPEAT_EN to build the autorepeat counters; otherwise repeat_o is tied to 0.
module debounce_bank #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned DELAY    = 250000,
    parameter int unsigned HOLD     = 25000000,
    parameter int unsigned REPEAT   = 6250000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy_i,
    output logic [CHANNELS-1:0] clean_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] held_o,
    output logic [CHANNELS-1:0] repeat_o,
    output logic                any_change_o
);

    localparam int unsigned DW = $clog2(DELAY + 1);
    localparam int unsigned HW = $clog2(HOLD + 1);

    if (CHANNELS < 32'd1 || CHANNELS > 32'd32 ||
        DELAY < 32'd1 || DELAY > 32'd16777215 ||
        HOLD < 32'd1 || HOLD > 32'd67108863 ||
        REPEAT < 32'd1 || REPEAT > 32'd16777215) begin : g_param_check
        $error("debounce_bank: parameter out of range");
    end

    logic [CHANNELS-1:0]         sync1_q, sync2_q;
    logic [CHANNELS-1:0]         cand_q, cand_d;
    logic [CHANNELS-1:0][DW-1:0] dcnt_q, dcnt_d;
    logic [CHANNELS-1:0][HW-1:0] hcnt_q, hcnt_d;
    logic [CHANNELS-1:0]         clean_q, clean_d;
    logic [CHANNELS-1:0]         rise_q, rise_d;
    logic [CHANNELS-1:0]         fall_q, fall_d;
    logic [CHANNELS-1:0]         held_q, held_d;
    logic                        any_q, any_d;

    // Stability tracking, clean level, edge pulses and long-press detection
    always_comb begin
        cand_d  = cand_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        held_d  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (sync2_q[i] != cand_q[i]) begin
                cand_d[i] = sync2_q[i];
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] != DW'(DELAY)) begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end

            if (dcnt_q[i] == DW'(DELAY)) begin
                clean_d[i] = cand_q[i];
            end

            rise_d[i] = clean_d[i] & ~clean_q[i];
            fall_d[i] = ~clean_d[i] & clean_q[i];

            // Hold count restarts at every rise so held lands exactly HOLD cycles later
            if (!clean_d[i] || rise_d[i]) begin
                hcnt_d[i] = '0;
            end else if (hcnt_q[i] != HW'(HOLD)) begin
                hcnt_d[i] = hcnt_q[i] + HW'(1);
            end

            held_d[i] = clean_d[i] && (hcnt_d[i] == HW'(HOLD));
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            held_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= noisy_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            held_q  <= held_d;
            any_q   <= any_d;
        end
    end

`ifdef DEBOUNCE_BANK_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT + 1);

    logic [CHANNELS-1:0][RW-1:0] rcnt_q, rcnt_d;
    logic [CHANNELS-1:0]         rep_q, rep_d;

    // First pulse when held asserts, then one every REPEAT cycles while held
    always_comb begin
        rcnt_d = '0;
        rep_d  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (held_d[i]) begin
                if (!held_q[i] || rcnt_q[i] == RW'(REPEAT - 1)) begin
                    rep_d[i]  = 1'b1;
                    rcnt_d[i] = '0;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rcnt_q <= '0;
            rep_q  <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
        end
    end

    assign repeat_o = rep_q;
`else
    assign repeat_o = '0;
`endif

    assign clean_o      = clean_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign held_o       = held_q;
    assign any_change_o = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed and random checks of debounce_bank against a sample-window reference model.
module tb_debounce_bank;

    localparam int unsigned CH   = 4;
    localparam int unsigned DL   = 8;
    localparam int unsigned HD   = 32;
    localparam int unsigned RP   = 8;
    localparam int          MAXE = 4096;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] noisy;
    logic [CH-1:0] clean, rise, fall, held, rep;
    logic          anyc;

    always #5 clock = ~clock;

    debounce_bank #(
        .CHANNELS(CH), .DELAY(DL), .HOLD(HD), .REPEAT(RP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .noisy_i     (noisy),
        .clean_o     (clean),
        .rise_o      (rise),
        .fall_o      (fall),
        .held_o      (held),
        .repeat_o    (rep),
        .any_change_o(anyc)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 10;

    // Model state: every sampled noisy bit, where the post-reset history starts, last rise edge
    logic          smp [CH][MAXE];
    int            chain [CH];
    int            rise_edge [CH];
    logic [CH-1:0] e_clean = '0, e_rise = '0, e_fall = '0, e_held = '0, e_rep = '0;
    logic          e_any = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    // clean takes value v once the last DELAY+1 samples (ending 3 edges ago) all equal v
    task automatic model_edge(input logic rst, input logic [CH-1:0] nz);
        int   lo;
        logic nc;
        bit   same;
        for (int c = 0; c < int'(CH); c++) begin
            if (rst) begin
                smp[c][edge_n]     = 1'b0;
                smp[c][edge_n - 1] = 1'b0;
                smp[c][edge_n - 2] = 1'b0;
                chain[c]  = edge_n - 2;
                e_clean[c] = 1'b0;
                e_rise[c]  = 1'b0;
                e_fall[c]  = 1'b0;
                e_held[c]  = 1'b0;
                e_rep[c]   = 1'b0;
            end else begin
                smp[c][edge_n] = nz[c];
                lo = edge_n - 3 - int'(DL);
                nc = e_clean[c];
                if (lo >= chain[c]) begin
                    same = 1'b1;
                    for (int k = lo + 1; k <= edge_n - 3; k++)
                        if (smp[c][k] !== smp[c][lo]) same = 1'b0;
                    if (same) nc = smp[c][lo];
                end
                e_rise[c] = nc & ~e_clean[c];
                e_fall[c] = ~nc & e_clean[c];
                if (e_rise[c]) rise_edge[c] = edge_n;
                e_clean[c] = nc;
                e_held[c]  = nc && (edge_n - rise_edge[c] >= int'(HD));
`ifdef DEBOUNCE_BANK_AUTOREPEAT_EN
                e_rep[c] = e_held[c] && ((edge_n - rise_edge[c] - int'(HD)) % int'(RP) == 0);
`else
                e_rep[c] = 1'b0;
`endif
            end
        end
        e_any = |(e_rise | e_fall);
    endtask

    task automatic step(input logic rst, input logic [CH-1:0] nz);
        reset = rst;
        noisy = nz;
        @(posedge clock);
        edge_n++;
        if (edge_n >= MAXE) begin
            $display("FAIL edge_budget: edge %0d reached limit %0d", edge_n, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        model_edge(rst, nz);
        #1;
        chk("clean", 32'(clean), 32'(e_clean));
        chk("rise",  32'(rise),  32'(e_rise));
        chk("fall",  32'(fall),  32'(e_fall));
        chk("held",  32'(held),  32'(e_held));
        chk("repeat", 32'(rep),  32'(e_rep));
        chk("any_change", 32'(anyc), 32'(e_any));
    endtask

    int            t0, ev_a, ev_b, cnt;
    logic [CH-1:0] rnz;

    initial begin
        for (int c = 0; c < int'(CH); c++) begin
            chain[c]     = 0;
            rise_edge[c] = 0;
        end
        reset = 1'b1;
        noisy = '0;

        // Reset with all inputs high, then one idle cycle: everything must read 0
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF);
        step(1'b0, 4'h0);
        chk("reset_release_outputs", 32'({clean, rise, fall, held, rep, anyc}), 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 4'h0);

        // Short pulse on channel 0 is swallowed
        cnt = 0;
        for (int i = 0; i < 5; i++) begin step(1'b0, 4'h1); cnt += int'(clean[0] | rise[0] | anyc); end
        for (int i = 0; i < 20; i++) begin step(1'b0, 4'h0); cnt += int'(clean[0] | rise[0] | anyc); end
        chk("short_pulse_quiet", 32'(cnt), 32'd0);

        // Glitch boundary: DELAY samples ignored, DELAY+1 samples accepted
        cnt = 0;
        for (int i = 0; i < int'(DL); i++) begin step(1'b0, 4'h1); cnt += int'(rise[0]); end
        for (int i = 0; i < 20; i++) begin step(1'b0, 4'h0); cnt += int'(rise[0]); end
        chk("glitch_delay_no_rise", 32'(cnt), 32'd0);
        cnt = 0;
        for (int i = 0; i < int'(DL) + 1; i++) begin step(1'b0, 4'h1); cnt += int'(rise[0]); end
        for (int i = 0; i < 20; i++) begin step(1'b0, 4'h0); cnt += int'(rise[0]); end
        chk("glitch_delay1_rise", 32'(cnt), 32'd1);

        // Channel 1: rise DELAY+3 edges after the first high sample, fall likewise after the drop
        t0 = edge_n + 1;
        ev_a = -1;
        for (int i = 0; i < 30; i++) begin step(1'b0, 4'h2); if (rise[1] && ev_a < 0) ev_a = edge_n; end
        chk("ch1_rise_edge", 32'(ev_a), 32'(t0 + int'(DL) + 3));
        t0 = edge_n + 1;
        ev_b = -1;
        for (int i = 0; i < 20; i++) begin step(1'b0, 4'h0); if (fall[1] && ev_b < 0) ev_b = edge_n; end
        chk("ch1_fall_edge", 32'(ev_b), 32'(t0 + int'(DL) + 3));

        // Channel 2 held for 60 cycles: held and autorepeat timing
        t0 = edge_n + 1;
        ev_a = -1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 4'h4);
            if (held[2] && ev_a < 0) ev_a = edge_n;
            cnt += int'(rep[2]);
        end
        for (int i = 0; i < 20; i++) begin step(1'b0, 4'h0); cnt += int'(rep[2]); end
        chk("ch2_held_edge", 32'(ev_a), 32'(t0 + int'(DL) + 3 + int'(HD)));
`ifdef DEBOUNCE_BANK_AUTOREPEAT_EN
        chk("ch2_repeat_count", 32'(cnt), 32'd4);
`else
        chk("ch2_repeat_count", 32'(cnt), 32'd0);
`endif

        // All channels change together: one any_change cycle, rise all ones
        cnt = 0;
        ev_a = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'hF);
            cnt += int'(anyc);
            if (rise == 4'hF) ev_a++;
        end
        chk("all_rise_any_count", 32'(cnt), 32'd1);
        chk("all_rise_together", 32'(ev_a), 32'd1);
        for (int i = 0; i < 60; i++) step(1'b0, 4'h0);

        // Reset mid-count on channel 3 discards progress; rise comes DELAY+3 after release
        for (int i = 0; i < 8; i++) step(1'b0, 4'h8);
        step(1'b1, 4'h8);
        t0 = edge_n + 1;
        ev_a = -1;
        for (int i = 0; i < 20; i++) begin step(1'b0, 4'h8); if (rise[3] && ev_a < 0) ev_a = edge_n; end
        chk("ch3_reset_rise_edge", 32'(ev_a), 32'(t0 + int'(DL) + 3));
        for (int i = 0; i < 20; i++) step(1'b0, 4'h0);

        // Random toggling with occasional resets
        rnz = '0;
        for (int i = 0; i < 900; i++) begin
            for (int c = 0; c < int'(CH); c++)
                if ($urandom_range(0, 11) == 0) rnz[c] = ~rnz[c];
            step($urandom_range(0, 299) == 0, rnz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 8: number of independent input channels, range 1..32.
REQ-002 The block SHALL have parameter DELAY, default 250000: stable cycles required before clean changes (0.01 s at 25 MHz), range 1..2^24-1.
REQ-003 The block SHALL have parameter HOLD, default 25000000: cycles clean must stay 1 before held asserts (1 s at 25 MHz), range 1..2^26-1.
REQ-004 The block SHALL have parameter REPEAT, default 6250000: autorepeat period in cycles, range 1..2^24-1.
REQ-005 The block SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port noisy  input  CHANNELS  raw asynchronous switch inputs.
REQ-008 The block SHALL have port clean  output  CHANNELS  debounced level per channel.
REQ-009 The block SHALL have port rise  output  CHANNELS  one-cycle pulse on the 0->1 change of clean.
REQ-010 The block SHALL have port fall  output  CHANNELS  one-cycle pulse on the 1->0 change of clean.
REQ-011 The block SHALL have port held  output  CHANNELS  level; clean has been 1 for at least HOLD cycles.
REQ-012 The block SHALL have port repeat  output  CHANNELS  autorepeat pulses; see Configuration.
REQ-013 The block SHALL have port any_change  output  1  OR of all rise and fall bits.

Function
REQ-014 Each noisy bit SHALL pass through a private two-flop synchronizer before any other use.
REQ-015 Per channel: when the synchronized value differs from the candidate register, the candidate SHALL load it and the stability counter SHALL clear to 0.
REQ-016 Otherwise the stability counter SHALL increment, saturating at DELAY with no wrap; in the cycle it equals DELAY, clean SHALL load the candidate.
REQ-017 Counter widths SHALL be $clog2(limit+1) for each limit; no counter ever overflows.
REQ-018 With noisy stable from rising edge 1, clean SHALL change on edge DELAY+4 and not earlier.
REQ-019 A noisy pulse or glitch shorter than DELAY+1 cycles SHALL NOT change clean.
REQ-020 rise/fall SHALL be registered and high for exactly the first cycle in which clean shows its new value.
REQ-021 The hold counter SHALL clear on the rise cycle, increment while clean=1, saturate at HOLD, and clear when clean=0.
REQ-022 held SHALL assert exactly HOLD cycles after the rise cycle and deassert in the fall cycle.
REQ-023 Channels SHALL be fully independent; simultaneous changes on any set of channels SHALL yield the same per-channel timing as isolated changes.
REQ-024 any_change SHALL be high for one cycle regardless of how many channels change in that cycle.

Reset
REQ-025 While reset=1, synchronizers, candidates, all counters, clean, rise, fall, held, repeat and any_change SHALL be 0.
REQ-026 Reset asserted mid-count SHALL discard progress; no rise, fall or repeat pulse SHALL occur in the reset cycle or the first cycle after release.
REQ-027 An input high through reset release SHALL produce a normal rise on edge DELAY+4 after release.

Configuration
REQ-028 Macro DEBOUNCE_BANK_AUTOREPEAT_EN defined: repeat[i] SHALL pulse one cycle when held[i] asserts, then every REPEAT cycles while held[i]=1, and stop in the fall cycle.
REQ-029 Macro undefined: repeat SHALL be constant 0, the repeat counters SHALL NOT be instantiated, and the port list SHALL be unchanged.

Verification (CHANNELS=4, DELAY=8, HOLD=32, REPEAT=8)
REQ-030 Reset with noisy=4'hF for 5 cycles -> all outputs 0 during reset and one cycle after.
REQ-031 noisy[0] high for 5 cycles then low -> clean[0], rise[0], any_change stay 0 throughout.
REQ-032 noisy[1] high from edge 1 -> clean[1]=1 and rise[1] pulse on edge 12; low for 20 cycles -> fall[1] pulse 12 edges after the drop.
REQ-033 noisy[2] held 60 cycles -> held[2] at rise+32; with macro repeat[2] at rise+32, +40, +48, ...; without macro repeat=0.
REQ-034 noisy 0->4'hF in one cycle -> rise=4'hF in a single cycle; any_change high exactly one cycle.
REQ-035 reset pulsed at stability count 5 on channel 3 -> clean[3] stays 0; rise[3] at edge DELAY+4 after release.
